// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - dequeues 32-bit words and sends BYTES_PER_WORD bytes LSB-first as 8N1 UART frames.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit before stop (8E1).
module uart_word_tx #(
  parameter int BAUD_DIV       = 100,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_deq,
  output logic        tx_out,
  output logic        busy,
  output logic        byte_done,
  output logic        word_done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
`ifdef UART_WORD_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic             wait_cnt_q, wait_cnt_d;
  logic             tx_q, tx_d;
  logic             deq_q, deq_d;
  logic             busy_q, busy_d;
  logic             byte_done_q, byte_done_d;
  logic             word_done_q, word_done_d;

  logic             baud_tc;
  logic [7:0]       cur_byte;

  assign baud_tc  = (baud_cnt_q == BAUD_LAST);
  assign cur_byte = word_q[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    wait_cnt_d  = wait_cnt_q;
    tx_d        = tx_q;
    deq_d       = 1'b0;
    byte_done_d = 1'b0;
    word_done_d = 1'b0;

    if (state_q != IDLE && state_q != WAIT) begin
      baud_cnt_d = baud_tc ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        // The request is registered, so WAIT is entered the cycle after it is seen.
        if (deq_q) begin
          state_d    = WAIT;
          wait_cnt_d = 1'b0;
        end else if (!fifo_empty) begin
          deq_d = 1'b1;
        end
      end
      WAIT: begin
        if (fifo_valid) begin
          word_d     = fifo_data;
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end else if (wait_cnt_q) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = 1'b1;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^cur_byte;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_tc) begin
          byte_done_d = 1'b1;
          if (byte_idx_q == BYTE_LAST) begin
            word_done_d = 1'b1;
            state_d     = IDLE;
            tx_d        = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      word_q      <= 32'd0;
      wait_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      deq_q       <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      wait_cnt_q  <= wait_cnt_d;
      tx_q        <= tx_d;
      deq_q       <= deq_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      word_done_q <= word_done_d;
    end
  end

  assign fifo_deq  = deq_q;
  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// tb/tb_uart_word_tx.sv - directed self-checking bench for uart_word_tx (BAUD_DIV=4, BYTES_PER_WORD=4).
module tb_uart_word_tx;

  localparam int BAUD = 4;
  localparam int BPW  = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int BYTE_CYC = FRAME * BAUD;
  localparam int WORD_CYC = BPW * BYTE_CYC;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_deq;
  logic        tx_out;
  logic        busy;
  logic        byte_done;
  logic        word_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  uart_word_tx #(.BAUD_DIV(BAUD), .BYTES_PER_WORD(BPW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_deq   (fifo_deq),
    .tx_out     (tx_out),
    .busy       (busy),
    .byte_done  (byte_done),
    .word_done  (word_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // n counts cycles from the first start-bit cycle of byte 0
  task automatic check_cycle(input logic [31:0] word, input int n);
    logic [7:0] b;
    logic       exp_tx;
    int         k;
    int         pos;
    k   = n / BYTE_CYC;
    pos = (n % BYTE_CYC) / BAUD;
    b   = 8'h00;
    for (int i = 0; i < 8; i++) if (k < BPW) b[i] = word[8*k + i];
    if (n >= WORD_CYC)                  exp_tx = 1'b1;
    else if (pos == 0)                  exp_tx = 1'b0;
    else if (pos <= 8)                  exp_tx = b[pos-1];
    else if (pos == 9 && FRAME == 11)   exp_tx = ^b;
    else                                exp_tx = 1'b1;
    check_eq($sformatf("tx n=%0d", n),        32'(tx_out),    32'(exp_tx));
    check_eq($sformatf("busy n=%0d", n),      32'(busy),      32'(n < WORD_CYC));
    check_eq($sformatf("byte_done n=%0d", n), 32'(byte_done), 32'(n > 0 && (n % BYTE_CYC) == 0));
    check_eq($sformatf("word_done n=%0d", n), 32'(word_done), 32'(n == WORD_CYC));
    check_eq($sformatf("deq n=%0d", n),       32'(fifo_deq),  32'd0);
  endtask

  task automatic start_word(input logic [31:0] word, input int exact_wait);
    int cyc;
    cyc = 0;
    while (!fifo_deq && cyc < 40) begin
      step();
      cyc++;
    end
    check_eq("deq_seen", 32'(fifo_deq), 32'd1);
    if (exact_wait >= 0) check_eq("deq_latency", 32'(cyc), 32'(exact_wait));
    check_eq("tx_before_word", 32'(tx_out), 32'd1);
    step();
    check_eq("deq_one_cycle", 32'(fifo_deq), 32'd0);
    check_eq("busy_in_wait", 32'(busy), 32'd1);
    check_eq("tx_in_wait", 32'(tx_out), 32'd1);
    fifo_valid = 1'b1;
    fifo_data  = word;
    step();
    fifo_valid = 1'b0;
    fifo_data  = 32'hFFFF_FFFF;
  endtask

  task automatic run_word(input logic [31:0] word, input int exact_wait, input bit glitch,
                          input logic empty_after);
    start_word(word, exact_wait);
    for (int n = 0; n <= WORD_CYC; n++) begin
      if (n > 0) step();
      check_cycle(word, n);
      fifo_valid = glitch && (n == 2 || n == 17 || n == BYTE_CYC + 38 || n == WORD_CYC - 1);
      fifo_data  = 32'hDEAD_BEEF;
      if (glitch && n == 10) fifo_empty = 1'b1;
      if (glitch && n == 90) fifo_empty = 1'b0;
      if (n == WORD_CYC) begin
        fifo_empty = empty_after;
        fifo_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic any_low;
    logic any_pulse;
    rst_in     = 1'b1;
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    fifo_data  = 32'd0;
    repeat (3) step();
    check_eq("rst_tx", 32'(tx_out), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_deq", 32'(fifo_deq), 32'd0);
    check_eq("rst_byte_done", 32'(byte_done), 32'd0);
    check_eq("rst_word_done", 32'(word_done), 32'd0);
    rst_in = 1'b0;
    step();
    check_eq("idle_empty_no_deq", 32'(fifo_deq), 32'd0);

    // single word, then two back-to-back words
    fifo_empty = 1'b0;
    run_word(32'h4433_2211, -1, 1'b0, 1'b0);
    run_word(32'hA5A5_A5A5, 1, 1'b0, 1'b0);
    run_word(32'h0000_FF00, 1, 1'b0, 1'b1);
    repeat (3) begin
      step();
      check_eq("empty_no_deq", 32'(fifo_deq), 32'd0);
    end

    // stray fifo_valid pulses and fifo_empty toggles during a frame
    fifo_empty = 1'b0;
    run_word(32'h5A3C_0FF0, -1, 1'b1, 1'b0);

    // lost-race timeout: deq with no fifo_valid
    start_word_timeout: begin
      int cyc;
      cyc = 0;
      while (!fifo_deq && cyc < 40) begin
        step();
        cyc++;
      end
      check_eq("to_deq_seen", 32'(fifo_deq), 32'd1);
      step();
      check_eq("to_wait1_busy", 32'(busy), 32'd1);
      check_eq("to_wait1_tx", 32'(tx_out), 32'd1);
      step();
      check_eq("to_wait2_busy", 32'(busy), 32'd1);
      check_eq("to_wait2_tx", 32'(tx_out), 32'd1);
      step();
      check_eq("to_idle_busy", 32'(busy), 32'd0);
      check_eq("to_idle_tx", 32'(tx_out), 32'd1);
      check_eq("to_idle_deq", 32'(fifo_deq), 32'd0);
      step();
      check_eq("to_redeq", 32'(fifo_deq), 32'd1);
    end
    run_word(32'h0000_00C3, 0, 1'b0, 1'b0);

    // parity-pattern word
    run_word(32'h0000_0007, 1, 1'b0, 1'b0);

    // reset during data bit 3 of byte 1
    start_word(32'h0000_00FF, 1);
    for (int n = 0; n <= BYTE_CYC + 17; n++) begin
      if (n > 0) step();
      check_cycle(32'h0000_00FF, n);
    end
    rst_in     = 1'b1;
    fifo_empty = 1'b1;
    step();
    check_eq("mid_rst_tx", 32'(tx_out), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_deq", 32'(fifo_deq), 32'd0);
    check_eq("mid_rst_byte_done", 32'(byte_done), 32'd0);
    check_eq("mid_rst_word_done", 32'(word_done), 32'd0);
    rst_in    = 1'b0;
    any_low   = 1'b0;
    any_pulse = 1'b0;
    repeat (200) begin
      step();
      any_low   = any_low | ~tx_out;
      any_pulse = any_pulse | byte_done | word_done | busy | fifo_deq;
    end
    check_eq("post_rst_tx_low", 32'(any_low), 32'd0);
    check_eq("post_rst_activity", 32'(any_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
